// File: rtl/multiple_sequencer.sv
// Load/store-multiple beat sequencer.
// It walks a 10-bit register list, lowest bit first. Each unstalled cycle it
// issues one register number and one word address.
module multiple_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  list_in,
    input  logic [31:0] base_addr,
    input  logic        stall,
    input  logic        flush,
    output logic        multiple_stable,
    output logic        multiple_pulse,
    output logic [9:0]  list_count,
    output logic [3:0]  reg_sel,
    output logic [31:0] addr_out,
    output logic        xfer_valid,
    output logic [31:0] wb_addr,
    output logic        done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t      state_q;
    logic [9:0]  list_q;
    logic [31:0] addr_q;
    logic [31:0] wb_q;
    logic        pulse_q;
    logic        done_q;

    logic        active;
    logic [9:0]  list_d;
    logic [31:0] addr_d;
    logic [31:0] wb_d;
    logic [3:0]  pop;
    logic [3:0]  sel;

    assign active = (state_q == ACTIVE);
    // Clearing the lowest set bit gives the list that remains after this beat.
    assign list_d = list_q & (list_q - 10'd1);
    assign addr_d = addr_q + 32'd4;

    // Writeback base = base + 4 * number of registers in the incoming list.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 10; i++) pop = pop + {3'b000, list_in[i]};
        wb_d = base_addr + {26'd0, pop, 2'b00};
    end

    // Register number of the lowest set bit; LR and PC map to 14 and 15.
    always_comb begin
        sel = '0;
        for (int i = 9; i >= 0; i--) begin
            if (list_q[i]) sel = (i < 8) ? 4'(i) : 4'(i + 6);
        end
    end

    assign multiple_stable = active;
    assign multiple_pulse  = pulse_q;
    assign list_count      = active ? list_d : '0;
    assign reg_sel         = active ? sel : '0;
    assign addr_out        = addr_q;
    assign wb_addr         = wb_q;
    assign xfer_valid      = active & ~stall & ~flush;
    assign done            = done_q;

    // Sequencer FSM. Flush wins over everything. Stall freezes an active
    // sequence, but it does not stop a new sequence from being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            list_q  <= '0;
            addr_q  <= '0;
            wb_q    <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= xfer_valid && (list_d == '0);
            if (flush) begin
                state_q <= IDLE;
                list_q  <= '0;
                pulse_q <= 1'b0;
            end else if (state_q == IDLE) begin
                if (start && (list_in != '0)) begin
                    state_q <= ACTIVE;
                    list_q  <= list_in;
                    addr_q  <= base_addr;
                    wb_q    <= wb_d;
                    pulse_q <= 1'b1;
                end
            end else if (!stall) begin
                list_q  <= list_d;
                addr_q  <= addr_d;
                pulse_q <= 1'b0;
                if (list_d == '0) state_q <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_multiple_sequencer.sv
// Bench for multiple_sequencer.
// A queue-based model of the remaining register list is checked every
// cycle. Directed literal checks pin the model to hand-computed values.
module tb_multiple_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  list_in = '0;
    logic [31:0] base_addr = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        multiple_stable, multiple_pulse, xfer_valid, done;
    logic [9:0]  list_count;
    logic [3:0]  reg_sel;
    logic [31:0] addr_out, wb_addr;

    int n_chk = 0;
    int n_fail = 0;

    multiple_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .list_in(list_in),
        .base_addr(base_addr), .stall(stall), .flush(flush),
        .multiple_stable(multiple_stable), .multiple_pulse(multiple_pulse),
        .list_count(list_count), .reg_sel(reg_sel), .addr_out(addr_out),
        .xfer_valid(xfer_valid), .wb_addr(wb_addr), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Model: the pending register bit numbers in transfer order, plus the
    // beat counter, from which every output is derived.
    int          m_q[$];
    bit          m_act, m_first, m_done;
    logic [31:0] m_base, m_wb;
    int          m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete(); m_act = 0; m_first = 0; m_done = 0;
            m_base = 0; m_wb = 0; m_k = 0;
        end else begin
            bit nd;
            nd = 0;
            if (flush) begin
                m_act = 0; m_first = 0; m_q.delete();
            end else if (m_act) begin
                if (!stall) begin
                    void'(m_q.pop_front());
                    m_k++; m_first = 0;
                    if (m_q.size() == 0) begin m_act = 0; nd = 1; end
                end
            end else if (start && list_in != 0) begin
                for (int b = 0; b < 10; b++) if (list_in[b]) m_q.push_back(b);
                m_base = base_addr; m_k = 0;
                m_wb = base_addr + 32'(4 * $countones(list_in));
                m_act = 1; m_first = 1;
            end
            m_done = nd;
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        logic [9:0] e_lc;
        logic [3:0] e_rs;
        e_lc = '0; e_rs = '0;
        if (m_act) begin
            e_rs = (m_q[0] < 8) ? 4'(m_q[0]) : 4'(m_q[0] + 6);
            for (int j = 1; j < m_q.size(); j++) e_lc[m_q[j]] = 1'b1;
        end
        chk("m_stable", 32'(multiple_stable), 32'(m_act));
        chk("m_pulse",  32'(multiple_pulse),  32'(m_act && m_first));
        chk("m_list_count", 32'(list_count), 32'(e_lc));
        chk("m_reg_sel", 32'(reg_sel), 32'(e_rs));
        chk("m_addr_out", addr_out, m_base + 32'(4 * m_k));
        chk("m_wb_addr", wb_addr, m_wb);
        chk("m_xfer_valid", 32'(xfer_valid), 32'(m_act && !stall && !flush));
        chk("m_done", 32'(done), 32'(m_done));
    end

    // Drive one cycle of inputs just after the rising edge, then land on the
    // falling edge so the caller can sample outputs.
    task automatic cyc(input logic s, input logic [9:0] l, input logic [31:0] b,
                       input logic st, input logic fl);
        @(posedge clk); #1;
        start = s; list_in = l; base_addr = b; stall = st; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle1();
        cyc(0, '0, '0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_stable", 32'(multiple_stable), 0);
        chk("rst_addr", addr_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // LDM r0,r1,r3; a start while active must be ignored
        cyc(1, 10'h00B, 32'h2000_0100, 0, 0);
        cyc(0, '0, '0, 0, 0);
        chk("b1_rs", 32'(reg_sel), 0); chk("b1_addr", addr_out, 32'h2000_0100);
        chk("b1_lc", 32'(list_count), 32'h00A); chk("b1_pulse", 32'(multiple_pulse), 1);
        chk("wb", wb_addr, 32'h2000_010C);
        cyc(1, 10'h3FF, 32'h0000_5000, 0, 0);
        chk("b2_rs", 32'(reg_sel), 1); chk("b2_addr", addr_out, 32'h2000_0104);
        chk("b2_lc", 32'(list_count), 32'h008); chk("b2_pulse", 32'(multiple_pulse), 0);
        cyc(0, '0, '0, 0, 0);
        chk("b3_rs", 32'(reg_sel), 3); chk("b3_addr", addr_out, 32'h2000_0108);
        chk("b3_lc", 32'(list_count), 0);
        idle1();
        chk("b_done", 32'(done), 1); chk("b_idle", 32'(multiple_stable), 0);
        idle1();
        chk("b_done_once", 32'(done), 0);

        // LR+PC with stall on the second active cycle
        cyc(1, 10'h300, 32'h0000_1000, 0, 0);
        cyc(0, '0, '0, 0, 0);
        chk("lp_rs14", 32'(reg_sel), 14); chk("lp_xv1", 32'(xfer_valid), 1);
        cyc(0, '0, '0, 1, 0);
        chk("lp_rs15a", 32'(reg_sel), 15); chk("lp_xv0", 32'(xfer_valid), 0);
        cyc(0, '0, '0, 0, 0);
        chk("lp_rs15b", 32'(reg_sel), 15); chk("lp_xv2", 32'(xfer_valid), 1);
        chk("lp_stable", 32'(multiple_stable), 1);
        idle1();
        chk("lp_done", 32'(done), 1); chk("lp_idle", 32'(multiple_stable), 0);

        // single-bit list
        cyc(1, 10'h010, 32'h0000_0040, 0, 0);
        cyc(0, '0, '0, 0, 0);
        chk("s_pulse", 32'(multiple_pulse), 1); chk("s_lc", 32'(list_count), 0);
        chk("s_rs", 32'(reg_sel), 4);
        idle1();
        chk("s_idle", 32'(multiple_stable), 0);

        // start accepted under stall; pulse holds until first beat goes
        cyc(1, 10'h005, 32'h0000_0200, 1, 0);
        cyc(0, '0, '0, 1, 0);
        chk("st_act", 32'(multiple_stable), 1); chk("st_pulse", 32'(multiple_pulse), 1);
        chk("st_xv", 32'(xfer_valid), 0);
        cyc(0, '0, '0, 0, 0);
        chk("st_pulse2", 32'(multiple_pulse), 1); chk("st_rs", 32'(reg_sel), 0);
        cyc(0, '0, '0, 0, 0);
        chk("st_rs2", 32'(reg_sel), 2); chk("st_addr", addr_out, 32'h0000_0204);
        idle1(); idle1();

        // flush on the second beat of a full low list; start dropped with it
        cyc(1, 10'h0FF, 32'h0000_3000, 0, 0);
        cyc(0, '0, '0, 0, 0);
        cyc(1, 10'h001, 32'h0000_7000, 1, 1);
        chk("f_rs", 32'(reg_sel), 1); chk("f_xv", 32'(xfer_valid), 0);
        idle1();
        chk("f_idle", 32'(multiple_stable), 0); chk("f_done", 32'(done), 0);
        chk("f_lc", 32'(list_count), 0);
        idle1();
        chk("f_done2", 32'(done), 0); chk("f_idle2", 32'(multiple_stable), 0);

        // address wrap
        cyc(1, 10'h003, 32'hFFFF_FFFC, 0, 0);
        cyc(0, '0, '0, 0, 0);
        chk("w_a0", addr_out, 32'hFFFF_FFFC); chk("w_wb", wb_addr, 32'h0000_0004);
        cyc(0, '0, '0, 0, 0);
        chk("w_a1", addr_out, 32'h0000_0000);
        idle1();

        // empty list start
        cyc(1, 10'h000, 32'h0000_0800, 0, 0);
        idle1();
        chk("z_idle", 32'(multiple_stable), 0); chk("z_done", 32'(done), 0);
        idle1();
        chk("z_done2", 32'(done), 0);

        // reset mid-sequence, then restart
        cyc(1, 10'h0FF, 32'h0000_9000, 0, 0);
        cyc(0, '0, '0, 0, 0);
        cyc(0, '0, '0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("r_stable", 32'(multiple_stable), 0); chk("r_rs", 32'(reg_sel), 0);
        chk("r_lc", 32'(list_count), 0); chk("r_addr", addr_out, 0);
        chk("r_wb", wb_addr, 0); chk("r_pulse", 32'(multiple_pulse), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        idle1();
        chk("r_nodone", 32'(done), 0);
        cyc(1, 10'h021, 32'h0000_A000, 0, 0);
        cyc(0, '0, '0, 0, 0);
        chk("r2_pulse", 32'(multiple_pulse), 1); chk("r2_rs", 32'(reg_sel), 0);
        chk("r2_wb", wb_addr, 32'h0000_A008);
        cyc(0, '0, '0, 0, 0);
        chk("r2_rs5", 32'(reg_sel), 5);
        idle1();
        chk("r2_done", 32'(done), 1);
        idle1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multiple_sequencer.md
MULTIPLE_SEQUENCER -- requirements
Module: multiple_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, listed first: clk (in, 1, rising-edge clock) and rst_n (in, 1, async active-low reset).
REQ-002 start  in  1  one-cycle request from decode that an LDM/STM/PUSH/POP is issued.
REQ-003 list_in  in  10  register list: bits 0-7 = r0-r7, bit 8 = LR, bit 9 = PC.
REQ-004 base_addr  in  32  first transfer address, already adjusted by decode for PUSH.
REQ-005 stall  in  1  pipeline hold; freezes all state.
REQ-006 flush  in  1  branch/kill; aborts any sequence.
REQ-007 multiple_stable  out  1  high for every cycle a sequence is active.
REQ-008 multiple_pulse  out  1  high only on the first active cycle of a sequence.
REQ-009 list_count  out  10  remaining list after the current beat; zero on the last beat.
REQ-010 reg_sel  out  4  register for the current beat: 0-7, 14 (LR), or 15 (PC).
REQ-011 addr_out  out  32  address for the current beat.
REQ-012 xfer_valid  out  1  current beat is valid and not stalled.
REQ-013 wb_addr  out  32  base writeback value: base_addr + 4 x popcount(list_in), latched at start.
REQ-014 done  out  1  one-cycle pulse after the last beat completes.

Function
REQ-015 FSM states SHALL be exactly IDLE and ACTIVE; the state register, list_reg[9:0], addr_reg[31:0], wb_reg[31:0], multiple_pulse and done SHALL be registered.
REQ-016 IDLE -> ACTIVE SHALL occur on start=1 and list_in!=0 and flush=0, loading list_reg=list_in, addr_reg=base_addr, wb_reg=base_addr+4*popcount(list_in).
REQ-017 start with list_in==0 SHALL be ignored: no state change and no done.
REQ-018 start while ACTIVE SHALL be ignored.
REQ-019 stall SHALL NOT block start acceptance in IDLE.
REQ-020 multiple_stable SHALL be 1 if and only if state==ACTIVE.
REQ-021 multiple_pulse SHALL be 1 on exactly the first ACTIVE cycle, including while stalled, and SHALL stay 1 until that first beat is accepted.
REQ-022 reg_sel SHALL be the index of the lowest set bit of list_reg, with bit 8 mapped to 14 and bit 9 to 15; it SHALL be 0 in IDLE.
REQ-023 list_count SHALL be list_reg with its lowest set bit cleared while ACTIVE, and 0 in IDLE.
REQ-024 addr_out SHALL equal addr_reg; wb_addr SHALL equal wb_reg.
REQ-025 xfer_valid SHALL equal (state==ACTIVE) and not stall and not flush.
REQ-026 On each beat with xfer_valid=1: list_reg <= list_count and addr_reg <= addr_reg+4, with 32-bit wrap-around modulo 2^32.
REQ-027 When xfer_valid=1 and list_count==0, the next state SHALL be IDLE and done SHALL pulse in the following cycle.
REQ-028 Latency SHALL be one beat per unstalled cycle, so N set bits take N ACTIVE cycles plus the stall cycles.
REQ-029 flush SHALL override stall and start: next state IDLE, list_reg cleared, no done, and a start in the same cycle is dropped.
REQ-030 stall=1 in ACTIVE SHALL hold list_reg, addr_reg, state and all outputs unchanged.
REQ-031 A single-bit list SHALL give multiple_pulse=1 and list_count=0 in the same cycle.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, clear all registers, and drive every output to 0, regardless of clk.
REQ-033 Reset asserted mid-sequence SHALL abort without a done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-034 start, list_in=10'h00B, base_addr=32'h2000_0100 -> beats reg_sel 0,1,3; addr_out 0x100, 0x104, 0x108; list_count 0x00A, 0x008, 0x000; wb_addr=0x2000_010C; done one cycle after the third beat.
REQ-035 list_in=10'h300 (LR+PC), stall=1 on the 2nd ACTIVE cycle -> reg_sel 14 for 1 cycle, then 15 held for 2 cycles with xfer_valid=0 then 1; multiple_stable=1 for 3 cycles.
REQ-036 list_in=10'h010 -> multiple_pulse=1, list_count=0 and reg_sel=4 in the same cycle; IDLE next cycle.
REQ-037 flush on the 2nd beat of list 10'h0FF -> IDLE next cycle, done never asserts, list_count=0.
REQ-038 base_addr=32'hFFFF_FFFC, list_in=10'h003 -> addr_out 0xFFFF_FFFC then 0x0000_0000; wb_addr=0x0000_0004.
REQ-039 Two cases: start with list_in=0 -> no activity; rst_n pulsed low mid-sequence -> all outputs 0 asynchronously, and a new start is accepted after release.
